// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: exception types, stall-bit
// indices, stall polarity constants and the sequencer state.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'b00,
    EXC_SYSCALL = 2'b01,
    EXC_BREAK   = 2'b10,
    EXC_ERTN    = 2'b11
  } exc_type_e;

  localparam int STALL_W     = 7;
  localparam int STALL_PC    = 0;
  localparam int STALL_IF    = 1;
  localparam int STALL_IFID  = 2;
  localparam int STALL_IDEX  = 3;
  localparam int STALL_EXMEM = 4;
  localparam int STALL_MEMWB = 5;
  localparam int STALL_WB    = 6;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_REDIRECT = 1'b1
  } ctrl_state_e;

  // A requester freezes its own register and everything upstream of it.
  function automatic logic [STALL_W-1:0] stall_upto(input int top);
    logic [STALL_W-1:0] v;
    for (int i = 0; i < STALL_W; i++) begin
      v[i] = (i <= top) ? Stop : NoStop;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Stall statistics: total cycles with the PC frozen, plus a sticky flag
// raised once the PC has been frozen for STALL_TIMEOUT consecutive cycles.
module pipeline_ctrl_stall_watchdog
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout
);

  localparam int RUN_W = (STALL_TIMEOUT < 1) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STALL_TIMEOUT);

  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic             timeout_q, timeout_d;
  logic             run_hit;

  assign run_hit = (run_cnt_q == RUN_MAX);

  always_comb begin
    run_cnt_d      = '0;
    stall_cycles_d = stall_cycles_q;
    if (stall_pc) begin
      run_cnt_d      = run_hit ? RUN_MAX : run_cnt_q + RUN_W'(1);
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    timeout_d = timeout_q | run_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q      <= '0;
      stall_cycles_q <= '0;
      timeout_q      <= 1'b0;
    end else begin
      run_cnt_q      <= run_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      timeout_q      <= timeout_d;
    end
  end

  // The flag is visible in the same cycle the run counter reaches the limit.
  assign stall_cycles  = stall_cycles_q;
  assign stall_timeout = timeout_q | run_hit;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer: merges stall requests, resolves MEM-stage
// exceptions/ertn and EX branch redirects into flushes and a new fetch PC.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int PC_W          = 32,
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic               mem_inst_valid,
  input  logic [1:0]         mem_excepttype,
  input  logic [PC_W-1:0]    mem_inst_pc,
  input  logic [PC_W-1:0]    csr_eentry,
  input  logic [PC_W-1:0]    csr_era,
  input  logic               ex_branch_flag,
  input  logic [PC_W-1:0]    ex_branch_target,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic               flush_front,
  output logic               new_pc_valid,
  output logic [PC_W-1:0]    new_pc,
  output logic               exc_commit,
  output logic [1:0]         exc_code,
  output logic [PC_W-1:0]    exc_era,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               stall_timeout
);

  ctrl_state_e        state_q, state_d;
  logic [PC_W-1:0]    redir_pc_q, redir_pc_d;
  logic [PC_W-1:0]    new_pc_q, new_pc_d;
  logic [1:0]         exc_code_q, exc_code_d;
  logic [PC_W-1:0]    exc_era_q, exc_era_d;
  logic [STALL_W-1:0] stall_req;
  logic               in_run;
  logic               redirecting;
  logic               exc_hit;
  logic               br_hit;

  always_comb begin
    stall_req = '0;
    if (!rst) begin
      if (stallreq_mem)      stall_req = stall_upto(STALL_MEMWB);
      else if (stallreq_ex)  stall_req = stall_upto(STALL_EXMEM);
      else if (stallreq_id)  stall_req = stall_upto(STALL_IDEX);
      else if (stallreq_if)  stall_req = stall_upto(STALL_IFID);
    end
    stall_req[STALL_WB] = NoStop;
  end

  assign in_run      = !rst && (state_q == ST_RUN);
  assign redirecting = !rst && (state_q == ST_REDIRECT);

  // An exception parked behind an outstanding memory access is taken once it drains.
  assign exc_hit = in_run && mem_inst_valid && (mem_excepttype != EXC_NONE) && !stallreq_mem;
  assign br_hit  = in_run && ex_branch_flag && !stall_req[STALL_EXMEM] && !exc_hit;

  always_comb begin
    flush        = exc_hit;
    flush_front  = br_hit;
    exc_commit   = exc_hit;
    stall        = (exc_hit || br_hit) ? '0 : stall_req;
    new_pc_valid = redirecting || br_hit;
    new_pc       = new_pc_q;
    if (redirecting)  new_pc = redir_pc_q;
    else if (br_hit)  new_pc = ex_branch_target;
    exc_code     = exc_hit ? mem_excepttype : exc_code_q;
    exc_era      = exc_hit ? mem_inst_pc    : exc_era_q;
  end

  always_comb begin
    new_pc_d   = new_pc;
    exc_code_d = exc_code;
    exc_era_d  = exc_era;
    redir_pc_d = redir_pc_q;
    if (exc_hit) begin
      redir_pc_d = (mem_excepttype == EXC_ERTN) ? csr_era : csr_eentry;
    end
    // REDIRECT always lasts one cycle; only an exception leaves RUN.
    state_d = exc_hit ? ST_REDIRECT : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      redir_pc_q <= '0;
      new_pc_q   <= '0;
      exc_code_q <= '0;
      exc_era_q  <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      new_pc_q   <= new_pc_d;
      exc_code_q <= exc_code_d;
      exc_era_q  <= exc_era_d;
    end
  end

  pipeline_ctrl_stall_watchdog #(
    .STALL_TIMEOUT (STALL_TIMEOUT),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk           (clk),
    .rst           (rst),
    .stall_pc      (stall[STALL_PC]),
    .stall_cycles  (stall_cycles),
    .stall_timeout (stall_timeout)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized and directed bench for pipeline_ctrl against a cycle-level
// behavioural model of the sequencer rules.
module tb_pipeline_ctrl;

  localparam int PC_W  = 32;
  localparam int TMO   = 4;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic             mem_inst_valid;
  logic [1:0]       mem_excepttype;
  logic [PC_W-1:0]  mem_inst_pc, csr_eentry, csr_era, ex_branch_target;
  logic             ex_branch_flag;
  logic [6:0]       stall;
  logic             flush, flush_front, new_pc_valid, exc_commit, stall_timeout;
  logic [PC_W-1:0]  new_pc, exc_era;
  logic [1:0]       exc_code;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_ctrl #(.PC_W(PC_W), .STALL_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .mem_inst_valid(mem_inst_valid), .mem_excepttype(mem_excepttype),
    .mem_inst_pc(mem_inst_pc), .csr_eentry(csr_eentry), .csr_era(csr_era),
    .ex_branch_flag(ex_branch_flag), .ex_branch_target(ex_branch_target),
    .stall(stall), .flush(flush), .flush_front(flush_front),
    .new_pc_valid(new_pc_valid), .new_pc(new_pc),
    .exc_commit(exc_commit), .exc_code(exc_code), .exc_era(exc_era),
    .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit          m_pend;
  logic [31:0] m_tgt, m_npc, m_era, m_total;
  logic [1:0]  m_code;
  int          m_run;
  bit          m_sticky;

  // expectations of the current cycle
  logic [6:0]  e_stall;
  bit          e_exc, e_br, e_npv, e_to;
  logic [31:0] e_npc, e_era;
  logic [1:0]  e_code;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    rst = 0; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    mem_inst_valid = 0; mem_excepttype = 0; mem_inst_pc = 0; csr_eentry = 0;
    csr_era = 0; ex_branch_flag = 0; ex_branch_target = 0;
  endtask

  task automatic model_reset();
    m_pend = 0; m_tgt = 0; m_npc = 0; m_era = 0; m_total = 0;
    m_code = 0; m_run = 0; m_sticky = 0;
  endtask

  task automatic settle();
    int lvl;
    logic [6:0] raw;
    #1;
    lvl = stallreq_mem ? 6 : stallreq_ex ? 5 : stallreq_id ? 4 : stallreq_if ? 3 : 0;
    raw = 7'((1 << lvl) - 1);
    if (rst) raw = 0;
    e_exc   = !rst && !m_pend && mem_inst_valid && (mem_excepttype != 0) && !stallreq_mem;
    e_br    = !rst && !m_pend && ex_branch_flag && !raw[4] && !e_exc;
    e_stall = (e_exc || e_br) ? 7'd0 : raw;
    e_npv   = !rst && (m_pend || e_br);
    e_npc   = (!rst && m_pend) ? m_tgt : e_br ? ex_branch_target : m_npc;
    e_code  = e_exc ? mem_excepttype : m_code;
    e_era   = e_exc ? mem_inst_pc : m_era;
    e_to    = m_sticky || (m_run == TMO);
    chk("stall", stall, e_stall);
    chk("flush", flush, e_exc);
    chk("flush_front", flush_front, e_br);
    chk("exc_commit", exc_commit, e_exc);
    chk("new_pc_valid", new_pc_valid, e_npv);
    chk("new_pc", new_pc, e_npc);
    chk("exc_code", exc_code, e_code);
    chk("exc_era", exc_era, e_era);
    chk("stall_cycles", stall_cycles, m_total);
    chk("stall_timeout", stall_timeout, e_to);
  endtask

  task automatic advance();
    if (rst) begin
      model_reset();
    end else begin
      m_npc    = e_npc;
      m_code   = e_code;
      m_era    = e_era;
      if (e_exc) m_tgt = (mem_excepttype == 2'b11) ? csr_era : csr_eentry;
      m_pend   = e_exc;
      m_sticky = e_to;
      if (e_stall[0]) begin
        m_run   = (m_run < TMO) ? m_run + 1 : TMO;
        m_total = m_total + 1;
      end else begin
        m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  initial begin
    clear_in();
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    step();

    // stall vector shapes
    clear_in(); stallreq_ex = 1;
    settle(); chk("stall_ex_only", stall, 7'b0011111); advance();
    stallreq_mem = 1;
    settle(); chk("stall_ex_mem", stall, 7'b0111111); advance();
    clear_in();
    settle(); chk("stall_none", stall, 7'b0000000); advance();

    // syscall
    mem_inst_valid = 1; mem_excepttype = 2'b01; mem_inst_pc = 32'h1c000040; csr_eentry = 32'h1c008000;
    settle();
    chk("sys_flush", flush, 1); chk("sys_commit", exc_commit, 1);
    chk("sys_era", exc_era, 32'h1c000040); chk("sys_stall", stall, 0);
    advance();
    clear_in();
    settle(); chk("sys_npv", new_pc_valid, 1); chk("sys_new_pc", new_pc, 32'h1c008000); advance();

    // ertn held behind a memory stall
    mem_inst_valid = 1; mem_excepttype = 2'b11; csr_era = 32'h1c000044; csr_eentry = 32'h1c008000;
    mem_inst_pc = 32'h1c000090; stallreq_mem = 1;
    for (int k = 0; k < 3; k++) begin
      settle(); chk("ertn_held", flush, 0); advance();
    end
    stallreq_mem = 0;
    settle(); chk("ertn_flush", flush, 1); advance();
    clear_in();
    settle(); chk("ertn_new_pc", new_pc, 32'h1c000044); advance();

    // exception beats branch
    mem_inst_valid = 1; mem_excepttype = 2'b10; csr_eentry = 32'h1c008000; mem_inst_pc = 32'h1c0000f0;
    ex_branch_flag = 1; ex_branch_target = 32'h1c000100;
    settle(); chk("exbr_flush", flush, 1); chk("exbr_front", flush_front, 0); advance();
    clear_in();
    settle(); chk("exbr_new_pc", new_pc, 32'h1c008000); advance();

    // branch waits on memory stall
    ex_branch_flag = 1; ex_branch_target = 32'h1c000200; stallreq_mem = 1;
    settle(); chk("br_held_front", flush_front, 0); advance();
    stallreq_mem = 0;
    settle();
    chk("br_front", flush_front, 1); chk("br_npv", new_pc_valid, 1); chk("br_new_pc", new_pc, 32'h1c000200);
    advance();
    clear_in(); step();

    // reset during REDIRECT drops the pending redirect
    mem_inst_valid = 1; mem_excepttype = 2'b01; csr_eentry = 32'h1c00abc0;
    step();
    clear_in(); rst = 1;
    settle(); chk("rst_redir_npv", new_pc_valid, 0); advance();
    rst = 0;
    settle(); chk("post_rst_npv", new_pc_valid, 0); advance();

    // watchdog
    rst = 1; step();
    clear_in(); stallreq_if = 1;
    for (int k = 1; k <= 6; k++) begin
      settle();
      if (k == 4) chk("wd_not_yet", stall_timeout, 0);
      if (k == 5) chk("wd_rise", stall_timeout, 1);
      advance();
    end
    clear_in();
    settle(); chk("wd_sticky", stall_timeout, 1); chk("wd_cycles", stall_cycles, 6); advance();
    rst = 1; step();
    rst = 0;
    settle(); chk("wd_rst_to", stall_timeout, 0); chk("wd_rst_cyc", stall_cycles, 0); advance();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      rst              = ($urandom % 64) == 0;
      stallreq_if      = ($urandom % 4) == 0;
      stallreq_id      = ($urandom % 5) == 0;
      stallreq_ex      = ($urandom % 5) == 0;
      stallreq_mem     = ($urandom % 5) == 0;
      mem_inst_valid   = ($urandom % 3) == 0;
      mem_excepttype   = 2'($urandom % 4);
      mem_inst_pc      = $urandom;
      csr_eentry       = $urandom;
      csr_era          = $urandom;
      ex_branch_flag   = ($urandom % 3) == 0;
      ex_branch_target = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central pipeline sequencer. It merges per-stage stall requests into the 7-bit stall vector consumed by every inter-stage register. It resolves exceptions and ertn reported by the MEM stage and branch redirects from EX into flush/flush_front and a new fetch PC. It also keeps stall statistics and a stall watchdog.

Parameters:
PC_W, 32, width of PC/CSR address values
STALL_TIMEOUT, 1023, consecutive stall[0] cycles before stall_timeout sets
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
stallreq_if  in  1  fetch stall request
stallreq_id  in  1  decode stall request
stallreq_ex  in  1  execute stall request (multi-cycle ALU)
stallreq_mem  in  1  memory stall request (outstanding access)
mem_inst_valid  in  1  MEM-stage instruction valid
mem_excepttype  in  2  00 none, 01 syscall, 10 break, 11 ertn
mem_inst_pc  in  PC_W  PC of the MEM-stage instruction
csr_eentry  in  PC_W  exception entry address
csr_era  in  PC_W  exception return address
ex_branch_flag  in  1  EX resolved a taken branch/redirect
ex_branch_target  in  PC_W  redirect target
stall  out  7  [0]PC [1]IF [2]IF/ID [3]ID/EX [4]EX/MEM [5]MEM/WB [6]WB
flush  out  1  clear all pipeline registers
flush_front  out  1  clear PC..ID/EX only (branch)
new_pc_valid  out  1  PC must load new_pc (priority over stall[0])
new_pc  out  PC_W  redirect target
exc_commit  out  1  one-cycle pulse: CSR unit updates state
exc_code  out  2  excepttype being committed
exc_era  out  PC_W  PC to record in ERA
stall_cycles  out  CNT_W  total cycles with stall[0]=1
stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: state=RUN. flush, flush_front, new_pc_valid, and exc_commit are 0. stall, new_pc, exc_code, exc_era, stall_cycles, and stall_timeout are 0. Internal counters are 0.
- Stall vector is combinational, driven by the highest requester:
  - mem sets bits 0..5
  - ex sets bits 0..4
  - id sets bits 0..3
  - if sets bits 0..2
  - stall[6] is always 0.
- Stall forcing: when flush=1 or flush_front=1 the stall vector is forced to 0 in that cycle. The downstream register gives flush priority anyway.
- exc_hit = mem_inst_valid & (mem_excepttype != 00) & !stallreq_mem & (state==RUN).
- When exc_hit (combinational, same cycle):
  - flush=1, exc_commit=1, exc_code=mem_excepttype, exc_era=mem_inst_pc.
  - The redirect target is latched: csr_era if the type is 11, else csr_eentry.
  - state goes to REDIRECT.
- A MEM exception while stallreq_mem=1 waits. The EX/MEM register holds it, and it is taken on the first cycle stallreq_mem=0.
- REDIRECT state:
  - lasts exactly 1 cycle.
  - new_pc_valid=1 and new_pc=latched target.
  - flush=0; stall is computed normally.
  - ex_branch_flag and exceptions are ignored.
  - returns to RUN.
- Branch redirect in RUN fires when ex_branch_flag & !stall[4] & !exc_hit. In the same cycle: flush_front=1, new_pc_valid=1, new_pc=ex_branch_target.
- A branch with stall[4]=1 waits; EX holds it.
- Exception beats branch in the same cycle; the branch is discarded because flush kills it.
- Watchdog:
  - run_cnt increments each cycle stall[0]=1 and clears on stall[0]=0.
  - run_cnt saturates at STALL_TIMEOUT.
  - stall_timeout sets when run_cnt==STALL_TIMEOUT and stays set until rst.
- stall_cycles increments every cycle stall[0]=1 and wraps at 2^CNT_W.
- new_pc and exc_code/exc_era hold their last values when not valid or not committing.
- rst mid-REDIRECT returns to RUN with no redirect pending.

Decomposition:
- Shared defines package holds:
  - excepttype encodings (EXC_NONE/SYSCALL/BREAK/ERTN)
  - stall bit indices (STALL_PC..STALL_WB)
  - Stop/NoStop constants
- One sub-module: stall_watchdog. It contains run_cnt, stall_timeout, and stall_cycles, and takes stall[0] as its input.

Test Plan:
- stallreq_ex=1 alone -> stall=7'b0011111. Add stallreq_mem=1 -> 7'b0111111. All requests 0 -> 7'b0000000.
- mem_excepttype=01, valid=1, pc=0x1c000040, eentry=0x1c008000:
  - same cycle: flush=1, exc_commit=1, exc_era=0x1c000040, stall=0.
  - next cycle: new_pc_valid=1, new_pc=0x1c008000.
- ertn (11) with csr_era=0x1c000044 held 3 cycles by stallreq_mem=1:
  - flush stays 0 while held.
  - flush pulses on the first cycle stallreq_mem=0.
  - next cycle: new_pc=0x1c000044.
- Same cycle exception 10 and ex_branch_flag with target 0x1c000100:
  - flush=1, flush_front=0.
  - the following new_pc equals eentry, not 0x1c000100.
- Branch with stallreq_mem=1 -> no flush_front. Release -> flush_front=1, new_pc=target, new_pc_valid=1 that cycle.
- STALL_TIMEOUT=4 with stallreq_if held 6 cycles:
  - stall_timeout rises on the 5th cycle and stays set after release.
  - stall_cycles=6.
  - rst clears both.
